// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps each instruction through fetch/decode/exec/mem/wb/pc-update.
// Optional build macro RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module multicycle_sequencer #(
  parameter int CLASS_W = 4,
  parameter int OP_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CLASS_W-1:0] instr_class,
  input  logic [OP_W-1:0]    branch_op_in,
  input  logic [OP_W-1:0]    stack_op_in,
  input  logic               mem_ack,
  input  logic               halt_req,
  output logic               ir_we,
  output logic               alu_en,
  output logic               lmd_we,
  output logic               reg_we,
  output logic               pc_en,
  output logic               sp_inc,
  output logic               sp_dec,
  output logic               mem_req,
  output logic               mem_we,
  output logic [OP_W-1:0]    branch_op,
  output logic [OP_W-1:0]    stack_op,
  output logic               busy,
  output logic               illegal,
  output logic [2:0]         state
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]        retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  localparam logic [CLASS_W-1:0] C_ALU    = CLASS_W'(0);
  localparam logic [CLASS_W-1:0] C_LOAD   = CLASS_W'(1);
  localparam logic [CLASS_W-1:0] C_STORE  = CLASS_W'(2);
  localparam logic [CLASS_W-1:0] C_BRANCH = CLASS_W'(3);
  localparam logic [CLASS_W-1:0] C_STACK  = CLASS_W'(4);
  localparam logic [CLASS_W-1:0] C_HALT   = CLASS_W'(6);

  localparam logic [OP_W-1:0] OP_PUSH = OP_W'(1);
  localparam logic [OP_W-1:0] OP_POP  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_CALL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_RET  = OP_W'(4);

  state_t             r_state;
  logic [CLASS_W-1:0] r_class;
  logic [OP_W-1:0]    r_bop;
  logic [OP_W-1:0]    r_sop;
  logic               r_illegal;

  logic w_isAlu, w_isLoad, w_isStore, w_isBranch, w_isStack;
  logic w_pushCall, w_popRet, w_isPop, w_stackValid;

  assign w_isAlu      = (r_class == C_ALU);
  assign w_isLoad     = (r_class == C_LOAD);
  assign w_isStore    = (r_class == C_STORE);
  assign w_isBranch   = (r_class == C_BRANCH);
  assign w_isStack    = (r_class == C_STACK);
  assign w_pushCall   = w_isStack && ((r_sop == OP_PUSH) || (r_sop == OP_CALL));
  assign w_popRet     = w_isStack && ((r_sop == OP_POP) || (r_sop == OP_RET));
  assign w_isPop      = w_isStack && (r_sop == OP_POP);
  assign w_stackValid = w_pushCall || w_popRet;

  // Illegal classes fall through EXEC's default arm and retire as a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_class   <= '0;
      r_bop     <= '0;
      r_sop     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_state <= S_FETCH;
        S_FETCH:  if (mem_ack) r_state <= S_DECODE;
        S_DECODE: begin
          r_class <= instr_class;
          r_bop   <= branch_op_in;
          r_sop   <= stack_op_in;
          if (instr_class == C_HALT) begin
            r_state <= S_HALTED;
          end else begin
            if (instr_class > C_HALT) r_illegal <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_isAlu)                                r_state <= S_WB;
          else if (w_isLoad || w_isStore || w_stackValid) r_state <= S_MEM;
          else                                        r_state <= S_PCUPD;
        end
        S_MEM: begin
          if (mem_ack) r_state <= (w_isLoad || w_isPop) ? S_WB : S_PCUPD;
        end
        S_WB:     r_state <= S_PCUPD;
        S_PCUPD:  r_state <= halt_req ? S_HALTED : S_FETCH;
        S_HALTED: if (start) r_state <= S_FETCH;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ir_we     = 1'b0;
    alu_en    = 1'b0;
    lmd_we    = 1'b0;
    reg_we    = 1'b0;
    pc_en     = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    branch_op = '0;
    stack_op  = '0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        sp_dec = w_pushCall;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = w_isStore || w_pushCall;
        lmd_we  = mem_ack && (w_isLoad || w_popRet);
        sp_inc  = mem_ack && w_popRet;
      end
      S_WB:    reg_we = 1'b1;
      S_PCUPD: begin
        pc_en     = 1'b1;
        branch_op = w_isBranch ? r_bop : '0;
        stack_op  = w_stackValid ? r_sop : '0;
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign illegal = r_illegal;
  assign state   = r_state;

`ifdef RETIRE_COUNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_retired <= '0;
    else if (pc_en) r_retired <= r_retired + 32'd1;
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: directed table, reset corner case and randomized instruction stream.
// Build with RETIRE_COUNT_EN defined to also check the retired-instruction counter.
module tb_multicycle_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] instr_class;
  logic [2:0] branch_op_in;
  logic [2:0] stack_op_in;
  logic       mem_ack;
  logic       halt_req;
  logic       ir_we, alu_en, lmd_we, reg_we, pc_en, sp_inc, sp_dec;
  logic       mem_req, mem_we, busy, illegal;
  logic [2:0] branch_op, stack_op, state;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  multicycle_sequencer #(.CLASS_W(4), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_class(instr_class),
    .branch_op_in(branch_op_in), .stack_op_in(stack_op_in),
    .mem_ack(mem_ack), .halt_req(halt_req),
    .ir_we(ir_we), .alu_en(alu_en), .lmd_we(lmd_we), .reg_we(reg_we),
    .pc_en(pc_en), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .mem_req(mem_req), .mem_we(mem_we),
    .branch_op(branch_op), .stack_op(stack_op),
    .busy(busy), .illegal(illegal), .state(state)
`ifdef RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic irWe, aluEn, lmdWe, regWe, pcEn, spInc, spDec, memReq, memWe, busy, illegal;
  } outs_t;

  // One expected clock cycle: what the bench drives and what the DUT must show.
  typedef struct packed {
    logic       start, halt, ack;
    logic [3:0] dcls;
    logic [2:0] dbop, dsop;
    logic [2:0] st;
    outs_t      o;
    logic [2:0] bop, sop;
  } cyc_t;

  typedef struct {
    logic [3:0] cls;
    logic [2:0] bop, sop;
    int         fw, mw;
    logic       halt;
    int         expLat;
    logic [2:0] expB, expS;
    logic       expIll;
  } vec_t;

  cyc_t        q[$];
  int          tests = 0;
  int          errors = 0;
  logic        expIll = 1'b0;
  int unsigned expRetired = 0;

  function automatic cyc_t newEntry(input logic [2:0] st);
    cyc_t e;
    e = '0;
    e.start     = 1'($urandom_range(0, 1));
    e.halt      = 1'($urandom_range(0, 1));
    e.ack       = 1'($urandom_range(0, 1));
    e.dcls      = 4'($urandom_range(0, 15));
    e.dbop      = 3'($urandom_range(0, 7));
    e.dsop      = 3'($urandom_range(0, 7));
    e.st        = st;
    e.o.busy    = 1'b1;
    e.o.illegal = expIll;
    return e;
  endfunction

  task automatic pushHalted();
    cyc_t e;
    e = newEntry(3'd7);
    e.o.busy = 1'b0;
    e.start = 1'b0;
    q.push_back(e);
    e = newEntry(3'd7);
    e.o.busy = 1'b0;
    e.start = 1'b1;
    q.push_back(e);
  endtask

  task automatic pushIdleStart();
    cyc_t e;
    e = newEntry(3'd0);
    e.o = '0;
    e.start = 1'b0;
    q.push_back(e);
    e = newEntry(3'd0);
    e.o = '0;
    e.start = 1'b1;
    q.push_back(e);
  endtask

  // Expected per-cycle trace of one instruction, derived from the phase rules of each class.
  task automatic buildTrace(input logic [3:0] cls, input logic [2:0] bop, input logic [2:0] sop,
                            input int fw, input int mw, input logic halt);
    cyc_t e;
    logic stackValid, pushCall, popRet, useMem, useWb;
    pushCall   = (cls == 4) && (sop == 1 || sop == 3);
    popRet     = (cls == 4) && (sop == 2 || sop == 4);
    stackValid = pushCall || popRet;
    useMem     = (cls == 1) || (cls == 2) || stackValid;
    useWb      = (cls == 0) || (cls == 1) || ((cls == 4) && (sop == 2));
    for (int i = 0; i <= fw; i++) begin
      e = newEntry(3'd1);
      e.ack = (i == fw);
      e.o.memReq = 1'b1;
      e.o.irWe = (i == fw);
      q.push_back(e);
    end
    e = newEntry(3'd2);
    e.dcls = cls;
    e.dbop = bop;
    e.dsop = sop;
    q.push_back(e);
    if (cls == 6) begin
      pushHalted();
      return;
    end
    if (cls >= 7) expIll = 1'b1;
    e = newEntry(3'd3);
    e.o.aluEn = 1'b1;
    e.o.spDec = pushCall;
    q.push_back(e);
    if (useMem) begin
      for (int i = 0; i <= mw; i++) begin
        e = newEntry(3'd4);
        e.ack = (i == mw);
        e.o.memReq = 1'b1;
        e.o.memWe = (cls == 2) || pushCall;
        e.o.lmdWe = (i == mw) && ((cls == 1) || popRet);
        e.o.spInc = (i == mw) && popRet;
        q.push_back(e);
      end
    end
    if (useWb) begin
      e = newEntry(3'd5);
      e.o.regWe = 1'b1;
      q.push_back(e);
    end
    e = newEntry(3'd6);
    e.halt = halt;
    e.o.pcEn = 1'b1;
    e.bop = (cls == 3) ? bop : 3'd0;
    e.sop = stackValid ? sop : 3'd0;
    q.push_back(e);
    expRetired++;
    if (halt) pushHalted();
  endtask

  task automatic applyStimulus(input cyc_t e);
    start        = e.start;
    halt_req     = e.halt;
    mem_ack      = e.ack;
    instr_class  = e.dcls;
    branch_op_in = e.dbop;
    stack_op_in  = e.dsop;
  endtask

  task automatic checkOutput(input cyc_t e, input string name);
    logic [19:0] got, exp;
    outs_t a;
    a = {ir_we, alu_en, lmd_we, reg_we, pc_en, sp_inc, sp_dec, mem_req, mem_we, busy, illegal};
    got = {state, a, branch_op, stack_op};
    exp = {e.st, e.o, e.bop, e.sop};
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got st=%0d outs=%b bop=%0d sop=%0d, want st=%0d outs=%b bop=%0d sop=%0d",
               name, $time, state, a, branch_op, stack_op, e.st, e.o, e.bop, e.sop);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic runTrace(input string name, output int busyCycles,
                          output logic [2:0] pcB, output logic [2:0] pcS);
    cyc_t e;
    busyCycles = 0;
    pcB = 3'd0;
    pcS = 3'd0;
    while (q.size() > 0) begin
      e = q.pop_front();
      applyStimulus(e);
      @(negedge clk);
      checkOutput(e, name);
      if (busy) busyCycles++;
      if (pc_en) begin
        pcB = branch_op;
        pcS = stack_op;
      end
      @(posedge clk);
      #1;
    end
  endtask

  vec_t tbl[12];

  initial begin
    cyc_t       e;
    int         lat;
    logic [2:0] pb, ps;
    logic [3:0] cls;
    bit         done;

    // class, bop, sop, fetch waits, mem waits, halt, latency, pc branch_op, pc stack_op, illegal after
    tbl[0]  = '{4'd0, 3'd0, 3'd0, 0, 0, 1'b0, 5, 3'd0, 3'd0, 1'b0};
    tbl[1]  = '{4'd1, 3'd2, 3'd3, 0, 3, 1'b0, 9, 3'd0, 3'd0, 1'b0};
    tbl[2]  = '{4'd3, 3'd4, 3'd1, 0, 0, 1'b0, 4, 3'd4, 3'd0, 1'b0};
    tbl[3]  = '{4'd4, 3'd1, 3'd3, 0, 0, 1'b0, 5, 3'd0, 3'd3, 1'b0};
    tbl[4]  = '{4'd4, 3'd0, 3'd4, 0, 1, 1'b0, 6, 3'd0, 3'd4, 1'b0};
    tbl[5]  = '{4'd2, 3'd0, 3'd0, 2, 0, 1'b0, 7, 3'd0, 3'd0, 1'b0};
    tbl[6]  = '{4'd4, 3'd0, 3'd1, 0, 0, 1'b0, 5, 3'd0, 3'd1, 1'b0};
    tbl[7]  = '{4'd4, 3'd0, 3'd2, 0, 0, 1'b0, 6, 3'd0, 3'd2, 1'b0};
    tbl[8]  = '{4'd5, 3'd3, 3'd3, 0, 0, 1'b0, 4, 3'd0, 3'd0, 1'b0};
    tbl[9]  = '{4'd9, 3'd4, 3'd2, 0, 0, 1'b0, 4, 3'd0, 3'd0, 1'b1};
    tbl[10] = '{4'd6, 3'd0, 3'd0, 0, 0, 1'b0, 2, 3'd0, 3'd0, 1'b1};
    tbl[11] = '{4'd0, 3'd0, 3'd0, 0, 0, 1'b1, 5, 3'd0, 3'd0, 1'b1};

    rst = 1'b0;
    e = '0;
    applyStimulus(e);
    #12;
    checkOutput(e, "reset state");
`ifdef RETIRE_COUNT_EN
    checkVal("retired after reset", retired, 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    pushIdleStart();
    runTrace("idle start", lat, pb, ps);

    for (int i = 0; i < 12; i++) begin
      buildTrace(tbl[i].cls, tbl[i].bop, tbl[i].sop, tbl[i].fw, tbl[i].mw, tbl[i].halt);
      runTrace($sformatf("vec%0d trace", i), lat, pb, ps);
      checkVal($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].expLat));
      checkVal($sformatf("vec%0d pc branch_op", i), 32'(pb), 32'(tbl[i].expB));
      checkVal($sformatf("vec%0d pc stack_op", i), 32'(ps), 32'(tbl[i].expS));
      checkVal($sformatf("vec%0d illegal", i), 32'(illegal), 32'(tbl[i].expIll));
    end
`ifdef RETIRE_COUNT_EN
    checkVal("retired after table", retired, expRetired);
`endif

    // Pull reset in the middle of a LOAD's memory wait; everything must drop before the next edge.
    buildTrace(4'd1, 3'd0, 3'd0, 0, 5, 1'b0);
    done = 1'b0;
    while (!done && q.size() > 0) begin
      e = q.pop_front();
      applyStimulus(e);
      @(negedge clk);
      checkOutput(e, "pre-reset load");
      if (e.st == 3'd4) begin
        rst = 1'b0;
        #1;
        e = '0;
        e.start = start;
        checkOutput(e, "async reset in MEM");
        done = 1'b1;
        #2;
        rst = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    q.delete();
    expIll = 1'b0;
    expRetired = 0;
`ifdef RETIRE_COUNT_EN
    checkVal("retired after mid reset", retired, 32'd0);
`endif
    @(posedge clk);
    #1;
    pushIdleStart();
    runTrace("idle restart", lat, pb, ps);

    for (int i = 0; i < 200; i++) begin
      cls = 4'($urandom_range(0, 19) % 16);
      if (i < 3) cls = 4'($urandom_range(0, 5));
      buildTrace(cls, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 (i >= 3) && ($urandom_range(0, 7) == 0));
      runTrace($sformatf("rand%0d cls%0d", i, cls), lat, pb, ps);
`ifdef RETIRE_COUNT_EN
      if (i == 2) checkVal("retired after three", retired, 32'd3);
      checkVal($sformatf("rand%0d retired", i), retired, expRetired);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RISC core.
- Steps each instruction through fetch, decode, execute, memory, writeback and PC-update phases.
- Issues the one-cycle enables for the IR, ALU, memory, LMD, register file, stack pointer and PC-update unit.
- Drives the PC unit's branch/stack opcodes only in the PC-update cycle. Handshakes with memory through a req/ack pair.

Parameters:
- CLASS_W, 4, width of instr_class
- OP_W, 3, width of branch_op/stack_op fields

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin/resume execution from IDLE or HALTED
- instr_class  in  CLASS_W  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 STACK, 5 NOP, 6 HALT, 7-15 illegal
- branch_op_in  in  OP_W  from decoder: 1 BR, 2 BPL, 3 BMI, 4 BZ
- stack_op_in  in  OP_W  from decoder: 1 PUSH, 2 POP, 3 CALL, 4 RET
- mem_ack  in  1  memory completed the current request this cycle
- halt_req  in  1  stop after the current instruction retires
- ir_we, alu_en, lmd_we, reg_we, pc_en, sp_inc, sp_dec  out  1 each  one-cycle strobes
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write qualifier for mem_req
- branch_op  out  OP_W  to PC unit
- stack_op  out  OP_W  to PC unit
- busy  out  1  high in every state except IDLE and HALTED
- illegal  out  1  sticky illegal-class flag
- state  out  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCUPD=6, HALTED=7.
- Reset (rst=0, async): state=IDLE, illegal=0, latched class/ops=0. Every output is 0, including branch_op and stack_op.
- Outputs are decoded from state. ir_we, lmd_we and sp_inc are additionally qualified by mem_ack in the same cycle.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0. Hold until mem_ack=1; in that cycle ir_we=1, next DECODE. An ack in the first FETCH cycle (zero-wait) is legal.
- DECODE:
  - Latch instr_class, branch_op_in, stack_op_in.
  - HALT -> HALTED.
  - Class 7-15: set illegal=1 and treat as NOP.
  - Otherwise -> EXEC.
- EXEC: alu_en=1. Next state by class:
  - ALU -> WB
  - LOAD, STORE -> MEM
  - BRANCH, NOP, illegal -> PCUPD
  - STACK PUSH/CALL: sp_dec=1 this cycle -> MEM
  - STACK POP/RET -> MEM
  - STACK with stack_op 0 or 5-7 -> PCUPD as NOP
- MEM: mem_req=1. mem_we=1 for STORE/PUSH/CALL. On mem_ack:
  - LOAD/POP/RET: lmd_we=1.
  - POP/RET: sp_inc=1.
  - LOAD/POP -> WB; others -> PCUPD.
- WB: reg_we=1 -> PCUPD.
- PCUPD: pc_en=1.
  - branch_op = latched op for BRANCH, else 0.
  - stack_op = latched op for STACK, else 0.
  - With both 0 the PC unit performs PC+1.
  - Next: halt_req=1 -> HALTED, else FETCH.
- branch_op/stack_op are 0 in every state other than PCUPD.
- HALTED: busy=0. start=1 -> FETCH (resume at the current PC).
- Latency with zero-wait memory: BRANCH/NOP 4 cycles; ALU/STORE/PUSH/CALL/RET 5; LOAD/POP 6. Each memory wait cycle adds 1.
- halt_req is sampled only in PCUPD. The in-flight instruction always completes.
- start is ignored while busy=1.
- mem_ack outside FETCH/MEM is ignored.
- rst asserted mid-instruction: immediate return to IDLE, all strobes drop asynchronously, and no partial PC update.
- illegal clears only on reset.

Optional Feature:
RETIRE_COUNT_EN:
- Defined: adds output retired[31:0]. Reset to 0; +1 on each pc_en cycle; wraps 0xFFFFFFFF -> 0; holds in HALTED/IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then start=1, ALU class, mem_ack tied 1 -> states 1,2,3,5,6,1. ir_we at cycle 1, alu_en at 3, reg_we at 4, pc_en at 5 with branch_op=0, stack_op=0.
- LOAD, mem_ack delayed 3 cycles in MEM -> mem_req high 4 consecutive cycles, mem_we=0. lmd_we coincides with ack, then reg_we, then pc_en.
- BRANCH with branch_op_in=4 (BZ) -> branch_op=4 only in the PCUPD cycle, 0 before and after, 4-cycle instruction.
- STACK CALL (stack_op_in=3) -> sp_dec in EXEC, mem_we=1 in MEM, stack_op=3 during pc_en. RET (4) -> mem_we=0, lmd_we and sp_inc on ack, stack_op=4 at pc_en.
- instr_class=9 -> illegal=1 and stays 1, pc_en with both ops 0. HALT class -> HALTED, busy=0; start=1 -> FETCH.
- rst driven low during MEM with mem_req=1 -> mem_req=0 and state=0 before the next clock edge. With RETIRE_COUNT_EN, retired=0 after reset and equals 3 after three instructions.
